// File: rtl/prng_jump_ctrl.sv
// Jump/long-jump sequencer for an external xoroshiro128+ stage: steps the PRNG
// 128 times, XOR-accumulates selected states, then reloads the accumulated state.
module prng_jump_ctrl #(
  parameter logic [63:0] JUMP0  = 64'hdf900294d8f554a5,
  parameter logic [63:0] JUMP1  = 64'h170865df4b3201fc,
  parameter logic [63:0] LJUMP0 = 64'hd2a98b26625eee7b,
  parameter logic [63:0] LJUMP1 = 64'hdddf9b1090aa7ac1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cg,
  input  logic        i_seedValid,
  input  logic [63:0] i_seedS0,
  input  logic [63:0] i_seedS1,
  input  logic        i_start,
  input  logic        i_long,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_prngCg,
  output logic        o_prngSeedValid,
  output logic [63:0] o_prngSeedS0,
  output logic [63:0] o_prngSeedS1,
  input  logic [63:0] i_prngS0,
  input  logic [63:0] i_prngS1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [6:0]   r_cnt;
  logic [63:0]  r_acc0;
  logic [63:0]  r_acc1;
  logic [127:0] r_poly;
  logic         r_done;
  logic         w_take;

  // Handshake: i_start is a request that is accepted only on an IDLE cycle
  // (o_busy=0); requests seen while o_busy=1 are dropped, never queued.
  assign w_take = r_poly[r_cnt];
  assign o_busy = (r_state == S_STEP) || (r_state == S_LOAD);
  assign o_done = r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
      r_acc0  <= 64'd0;
      r_acc1  <= 64'd0;
      r_poly  <= 128'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_LOAD);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cnt  <= 7'd0;
            r_acc0 <= 64'd0;
            r_acc1 <= 64'd0;
            r_poly <= i_long ? {LJUMP1, LJUMP0} : {JUMP1, JUMP0};
          end
        end
        S_STEP: begin
          // The PRNG state seen here is the pre-advance state for this bit.
          if (w_take) begin
            r_acc0 <= r_acc0 ^ i_prngS0;
            r_acc1 <= r_acc1 ^ i_prngS1;
          end
          r_cnt <= r_cnt + 7'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next          = r_state;
    o_prngCg        = i_cg;
    o_prngSeedValid = i_seedValid;
    o_prngSeedS0    = i_seedS0;
    o_prngSeedS1    = i_seedS1;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_STEP;
      end
      S_STEP: begin
        o_prngCg        = 1'b1;
        o_prngSeedValid = 1'b0;
        o_prngSeedS0    = r_acc0;
        o_prngSeedS1    = r_acc1;
        if (r_cnt == 7'd127) w_next = S_LOAD;
      end
      S_LOAD: begin
        o_prngCg        = 1'b1;
        o_prngSeedValid = 1'b1;
        o_prngSeedS0    = r_acc0;
        o_prngSeedS1    = r_acc1;
        w_next          = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
